// File: rtl/fifo_sync.sv
// fifo_sync: single-clock parametrised FIFO with fill count, almost-full /
// almost-empty thresholds and sticky overflow/underflow flags.
// Compile-time option FIFO_FWFT_EN selects first-word-fall-through reads
// (head word always presented on o_rdata); otherwise o_rdata is a registered
// one-cycle-latency read port.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module fifo_sync #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_rd,
    input  logic                  i_err_clr,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_almost_full,
    output logic                  o_almost_empty,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [PW-1:0] DEPTH_LVL  = PW'(DEPTH);
    localparam logic [PW-1:0] AFULL_LVL  = PW'(AFULL_THRESH);
    localparam logic [PW-1:0] AEMPTY_LVL = PW'(AEMPTY_THRESH);

    logic [PW-1:0]         wptr_reg, wptr_next;
    logic [PW-1:0]         rptr_reg, rptr_next;
    logic [PW-1:0]         count;
    logic                  full, empty;
    logic                  wr_accept, rd_accept;
    logic                  overflow_reg, overflow_next;
    logic                  underflow_reg, underflow_next;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Status is decoded purely from the registered pointers.
    assign count     = wptr_reg - rptr_reg;
    assign full      = (count == DEPTH_LVL);
    assign empty     = (count == '0);
    assign wr_accept = i_wr && !full;
    assign rd_accept = i_rd && !empty;

    // Next-state for pointers and sticky error flags (a new error beats a clear).
    always_comb begin
        wptr_next      = wptr_reg;
        rptr_next      = rptr_reg;
        overflow_next  = (overflow_reg && !i_err_clr) || (i_wr && full);
        underflow_next = (underflow_reg && !i_err_clr) || (i_rd && empty);
        if (wr_accept) begin
            wptr_next = wptr_reg + PW'(1);
        end
        if (rd_accept) begin
            rptr_next = rptr_reg + PW'(1);
        end
    end

    // Pointer and error-flag registers; reset discards everything.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wptr_reg      <= '0;
            rptr_reg      <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            wptr_reg      <= wptr_next;
            rptr_reg      <= rptr_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    // Storage array: written on accepted writes only, never reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst && wr_accept) begin
            mem[wptr_reg[ADDR_WIDTH-1:0]] <= i_wdata;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word falls through; contents are meaningless while empty.
    assign o_rdata = mem[rptr_reg[ADDR_WIDTH-1:0]];
`else
    logic [DATA_WIDTH-1:0] rdata_reg;

    // Registered read port: updates only on an accepted read, holds otherwise.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rdata_reg <= '0;
        end else if (rd_accept) begin
            rdata_reg <= mem[rptr_reg[ADDR_WIDTH-1:0]];
        end
    end

    assign o_rdata = rdata_reg;
`endif

    assign o_full         = full;
    assign o_empty        = empty;
    assign o_almost_full  = (count >= AFULL_LVL);
    assign o_almost_empty = (count <= AEMPTY_LVL);
    assign o_count        = count;
    assign o_overflow     = overflow_reg;
    assign o_underflow    = underflow_reg;

endmodule

// File: tb/tb_fifo_sync.sv
// tb_fifo_sync: directed self-checking bench for fifo_sync (8-bit x 16).
// Read-data checks are placed before the pop in FWFT builds (FIFO_FWFT_EN)
// and after the pop in standard builds.
module tb_fifo_sync;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_wr = 1'b0;
    logic [7:0] i_wdata = 8'h00;
    logic       i_rd = 1'b0;
    logic       i_err_clr = 1'b0;
    logic [7:0] o_rdata;
    logic       o_full, o_empty, o_almost_full, o_almost_empty;
    logic [4:0] o_count;
    logic       o_overflow, o_underflow;

    int checks = 0;
    int errors = 0;

    fifo_sync #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(4),
        .AFULL_THRESH(12),
        .AEMPTY_THRESH(4)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_wr(i_wr),
        .i_wdata(i_wdata),
        .i_rd(i_rd),
        .i_err_clr(i_err_clr),
        .o_rdata(o_rdata),
        .o_full(o_full),
        .o_empty(o_empty),
        .o_almost_full(o_almost_full),
        .o_almost_empty(o_almost_empty),
        .o_count(o_count),
        .o_overflow(o_overflow),
        .o_underflow(o_underflow)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given request; optional read-data check on the popped word.
    task automatic xfer(input logic wr, input logic [7:0] wd, input logic rd,
                        input logic chk_rd, input logic [7:0] exp_rd);
`ifdef FIFO_FWFT_EN
        if (chk_rd) chk("rdata", {24'h0, o_rdata}, {24'h0, exp_rd});
`endif
        i_wr    = wr;
        i_wdata = wd;
        i_rd    = rd;
        @(posedge i_clk);
        #1;
        i_wr = 1'b0;
        i_rd = 1'b0;
        $display("t=%0t wr=%0b wd=%02h rd=%0b count=%0d rdata=%02h ovf=%0b unf=%0b",
                 $time, wr, wd, rd, o_count, o_rdata, o_overflow, o_underflow);
`ifndef FIFO_FWFT_EN
        if (chk_rd) chk("rdata", {24'h0, o_rdata}, {24'h0, exp_rd});
`endif
    endtask

    task automatic clr_err();
        i_err_clr = 1'b1;
        @(posedge i_clk);
        #1;
        i_err_clr = 1'b0;
        chk("ovf_clr", {31'h0, o_overflow}, 32'd0);
        chk("unf_clr", {31'h0, o_underflow}, 32'd0);
    endtask

    task automatic chk_count(input int exp);
        chk("count", {27'h0, o_count}, exp);
    endtask

    initial begin
        logic [7:0] q[$];
        int cnt, written, cyc_n;
        logic w, r;
        logic [7:0] head;

        // Reset held two cycles with a write request active
        i_wr = 1'b1;
        i_wdata = 8'h77;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        i_wr  = 1'b0;
        chk_count(0);
        chk("rst_empty", {31'h0, o_empty}, 32'd1);
        chk("rst_aempty", {31'h0, o_almost_empty}, 32'd1);
        chk("rst_full", {31'h0, o_full}, 32'd0);
        chk("rst_afull", {31'h0, o_almost_full}, 32'd0);
        chk("rst_ovf", {31'h0, o_overflow}, 32'd0);
        chk("rst_unf", {31'h0, o_underflow}, 32'd0);
`ifndef FIFO_FWFT_EN
        chk("rst_rdata", {24'h0, o_rdata}, 32'h0);
`endif
        xfer(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        chk_count(0);

        // Fill 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            xfer(1'b1, 8'(i), 1'b0, 1'b0, 8'h00);
            chk_count(i + 1);
            chk("fill_afull", {31'h0, o_almost_full}, (i + 1 >= 12) ? 32'd1 : 32'd0);
            chk("fill_full", {31'h0, o_full}, (i + 1 == 16) ? 32'd1 : 32'd0);
            chk("fill_aempty", {31'h0, o_almost_empty}, (i + 1 <= 4) ? 32'd1 : 32'd0);
            chk("fill_empty", {31'h0, o_empty}, 32'd0);
        end

        // Overflow, clear, then set-beats-clear
        xfer(1'b1, 8'hAA, 1'b0, 1'b0, 8'h00);
        chk("ovf_set", {31'h0, o_overflow}, 32'd1);
        chk_count(16);
        clr_err();
        i_err_clr = 1'b1;
        xfer(1'b1, 8'hAA, 1'b0, 1'b0, 8'h00);
        i_err_clr = 1'b0;
        chk("ovf_set_wins", {31'h0, o_overflow}, 32'd1);
        clr_err();

        // Drain 0x00..0x0F in order
        for (int i = 0; i < 16; i++) begin
            xfer(1'b0, 8'h00, 1'b1, 1'b1, 8'(i));
            chk_count(15 - i);
        end
        chk("drain_empty", {31'h0, o_empty}, 32'd1);

        // Underflow on empty
        xfer(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        chk("unf_set", {31'h0, o_underflow}, 32'd1);
        chk_count(0);
`ifndef FIFO_FWFT_EN
        chk("rdata_hold", {24'h0, o_rdata}, 32'h0F);
`endif
        clr_err();

        // Count 5, then three simultaneous write+read cycles
        for (int i = 0; i < 5; i++) xfer(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0, 8'h00);
        chk_count(5);
        for (int i = 0; i < 3; i++) begin
            xfer(1'b1, 8'h15 + 8'(i), 1'b1, 1'b1, 8'h10 + 8'(i));
            chk_count(5);
        end
        for (int i = 0; i < 5; i++) xfer(1'b0, 8'h00, 1'b1, 1'b1, 8'h13 + 8'(i));
        chk_count(0);

        // Simultaneous on empty: write accepted, read rejected
        xfer(1'b1, 8'h33, 1'b1, 1'b0, 8'h00);
        chk_count(1);
        chk("empty_wr_rd_unf", {31'h0, o_underflow}, 32'd1);
        xfer(1'b0, 8'h00, 1'b1, 1'b1, 8'h33);
        clr_err();

        // Simultaneous on full: read accepted, write rejected
        for (int i = 0; i < 16; i++) xfer(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0, 8'h00);
        chk("full2", {31'h0, o_full}, 32'd1);
        xfer(1'b1, 8'hBB, 1'b1, 1'b1, 8'h20);
        chk_count(15);
        chk("full_wr_rd_ovf", {31'h0, o_overflow}, 32'd1);
        for (int i = 1; i < 16; i++) xfer(1'b0, 8'h00, 1'b1, 1'b1, 8'h20 + 8'(i));
        chk("drain2_empty", {31'h0, o_empty}, 32'd1);
        clr_err();

        // Stream 40 words with the level held within 1..8
        cnt = 0;
        written = 0;
        cyc_n = 0;
        while ((written < 40 || cnt > 0) && cyc_n < 300) begin
            w = (written < 40) && (cnt < 8) && ((cyc_n % 5) != 0 || cnt <= 1);
            r = (cnt > 1 && (cyc_n % 3) != 0) || (written == 40 && cnt > 0) || cnt == 8;
            head = (r && cnt > 0) ? q[0] : 8'h00;
            xfer(w, 8'h40 + 8'(written), r, r && cnt > 0, head);
            if (r && cnt > 0) begin
                void'(q.pop_front());
                cnt--;
            end
            if (w) begin
                q.push_back(8'h40 + 8'(written));
                written++;
                cnt++;
            end
            chk_count(cnt);
            chk("wrap_aempty", {31'h0, o_almost_empty}, (cnt <= 4) ? 32'd1 : 32'd0);
            cyc_n++;
        end
        chk("wrap_done", cyc_n < 300 ? 32'd1 : 32'd0, 32'd1);
        chk("wrap_empty", {31'h0, o_empty}, 32'd1);

        // Single word into an empty FIFO, then pop it
        xfer(1'b1, 8'h5C, 1'b0, 1'b0, 8'h00);
        chk("single_empty", {31'h0, o_empty}, 32'd0);
`ifdef FIFO_FWFT_EN
        chk("fwft_rdata", {24'h0, o_rdata}, 32'h5C);
`endif
        xfer(1'b0, 8'h00, 1'b1, 1'b1, 8'h5C);
        chk("single_pop_empty", {31'h0, o_empty}, 32'd1);
        chk("no_errors", {30'h0, o_overflow, o_underflow}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_sync.md
# fifo_sync

Single-clock, parametrised synchronous FIFO; next generation of the team's FIFO family for same-domain buffering between pipeline stages. Adds configurable data width and depth, a fill-level count, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags. An optional first-word-fall-through (FWFT) read mode is selected at compile time.

## Interface

- `DATA_WIDTH`, default 8: word width in bits.
- `ADDR_WIDTH`, default 4: log2 of depth; `DEPTH = 2**ADDR_WIDTH` (default 16).
- `AFULL_THRESH`, default 12: `o_almost_full` asserts when count >= this value. Legal range: 1..DEPTH.
- `AEMPTY_THRESH`, default 4: `o_almost_empty` asserts when count <= this value. Legal range: 0..DEPTH-1.

Ports:

- `i_clk` input 1: sole clock; all logic on its rising edge.
- `i_rst` input 1: synchronous, active-high reset.
- `i_wr` input 1: write request.
- `i_wdata` input DATA_WIDTH: write data.
- `i_rd` input 1: read request.
- `i_err_clr` input 1: clears `o_overflow` and `o_underflow`.
- `o_rdata` output DATA_WIDTH: read data.
- `o_full` output 1: count == DEPTH.
- `o_empty` output 1: count == 0.
- `o_almost_full` output 1: count >= AFULL_THRESH.
- `o_almost_empty` output 1: count <= AEMPTY_THRESH.
- `o_count` output ADDR_WIDTH+1: current fill level, 0..DEPTH.
- `o_overflow` output 1: sticky; a write was attempted while full.
- `o_underflow` output 1: sticky; a read was attempted while empty.

## Operation

- **Pointers.**
  - Write and read pointers are ADDR_WIDTH+1 bits wide. The MSB is the wrap bit.
  - Memory index = pointer[ADDR_WIDTH-1:0].
  - `o_count = wptr - rptr`, computed modulo 2^(ADDR_WIDTH+1).
- **Accepting writes and reads.**
  - A write is accepted iff `i_wr && !o_full`. An accepted write stores `i_wdata` at wptr, then wptr increments.
  - A read is accepted iff `i_rd && !o_empty`. An accepted read increments rptr.
- **Simultaneous write and read.**
  - Both are evaluated against the current-cycle flags.
  - Not full and not empty: both are accepted and the count is unchanged.
  - Full: the read is accepted and the write is rejected (no pass-through).
  - Empty: the write is accepted and the read is rejected (no bypass).
- **Rejected operations.**
  - A rejected write sets `o_overflow`. A rejected read sets `o_underflow`.
  - A rejected operation leaves the memory, pointers and count unchanged.
- **Sticky error flags.**
  - Cleared by `i_rst`, or by `i_err_clr`.
  - If `i_err_clr` and a new error occur in the same cycle, the set wins.
- **Status outputs.** All flags and `o_count` are decoded from registered pointers only. There is no combinational path from inputs to status outputs.
- **Wrap-around.** Pointers roll over naturally. Full vs. empty is distinguished by the wrap bit: full means the low bits are equal and the MSBs differ.
- **Reset values.**
  - Pointers = 0, `o_count` = 0.
  - `o_empty` = 1, `o_almost_empty` = 1.
  - `o_full` = 0, `o_almost_full` = 0.
  - `o_overflow` = 0, `o_underflow` = 0.
  - `o_rdata` = 0 in standard mode.
  - Memory contents are not reset.
- **Reset mid-operation.** Reset discards all stored data and overrides any same-cycle `i_wr` or `i_rd`; no write or read is accepted in that cycle.

## Timing

- **Write to status.** Write accepted at edge N: `o_count`, `o_empty` and the almost/full flags reflect it after edge N.
- **Read latency, standard mode.**
  - Read accepted at edge N: `o_rdata` is registered and valid after edge N.
  - `o_rdata` holds its value until the next accepted read.
- **Minimum write-to-read-data latency, standard mode.** Write at edge N, read request at edge N+1, data valid after edge N+1: two cycles.
- **Throughput.** One write and one read per cycle sustained.

## Configuration

- **`FIFO_FWFT_EN` defined (first-word-fall-through).**
  - `o_rdata = mem[rptr]` whenever `!o_empty`. `i_rd` acknowledges (pops) the head word.
  - Write at edge N: the word is visible on `o_rdata` after edge N, together with `o_empty` deasserting.
  - `o_rdata` is undefined while `o_empty` is high.
  - Read data needs no reset.
- **`FIFO_FWFT_EN` undefined (standard mode).** Registered `o_rdata` with one-cycle read latency, as in Timing.
- **Unchanged in both modes.** Flags, count, and acceptance rules.

## Test plan

All scenarios use DATA_WIDTH=8, ADDR_WIDTH=4.

- **Reset:** assert `i_rst` 2 cycles with `i_wr=1` -> `o_count=0`, `o_empty=1`, `o_almost_empty=1`, `o_full=0`, errors 0; nothing written.
- **Fill and drain:**
  - Write 0x00..0x0F on 16 consecutive cycles -> `o_almost_full` rises when count reaches 12, `o_full=1` at count 16.
  - Read 16 -> data 0x00..0x0F in order, `o_empty=1` at end.
- **Overflow:** when full, write 0xAA -> `o_overflow=1`, `o_count` stays 16, and 0xAA never appears on read; pulse `i_err_clr` -> `o_overflow=0`.
- **Underflow and simultaneous ops:**
  - When empty, `i_rd=1` -> `o_underflow=1`, `o_count=0`.
  - With count 5, `i_wr` and `i_rd` both high for 3 cycles -> count stays 5, data order preserved.
  - When full, simultaneous write and read -> count 15, write rejected, overflow set.
- **Wrap-around:** run 40 words streamed with count held between 1 and 8 -> pointers wrap twice; every word read back in order; `o_almost_empty` tracks count <= 4.
- **FWFT build:** write 0x5C into empty FIFO -> `o_rdata=0x5C` one cycle later with `o_empty=0`; `i_rd` -> `o_empty=1` next cycle.
